axi_stream_dut_bridge: RTL and testbench

AXI4 full slave that carries burst traffic to and from a streaming DUT, such as the Benes interconnect.
- Write bursts fill an input FIFO, and a feed engine drives the DUT one beat per cycle.
- DUT results are captured in an output FIFO and drained by read bursts.
- Read and write proceed concurrently. There is no AW/AR mutual exclusion.

---
 rtl/axi_stream_dut_bridge_pkg.sv | 17 +
 rtl/axi_stream_dut_bridge_if.sv | 53 +++++
 rtl/axi_stream_dut_bridge_sync_fifo.sv | 54 +++++
 rtl/axi_stream_dut_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_axi_stream_dut_bridge.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_stream_dut_bridge_pkg.sv
// Shared types and constants for the AXI4 burst <-> streaming DUT bridge.
package axi_bridge_pkg;

    localparam int unsigned LEN_W = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
    typedef enum logic       {RD_IDLE, RD_DATA}          rd_state_t;

    // Saturating increment for the 32-bit statistics counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/axi_stream_dut_bridge_if.sv
// AXI4 slave channel bundle (AW/W/B/AR/R) used between master and bridge.
interface axi_stream_dut_bridge_if #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned DATA_W = 512
);
    logic [ID_W-1:0]   S_AXI_AWID;
    logic [7:0]        S_AXI_AWLEN;
    logic              S_AXI_AWVALID;
    logic              S_AXI_AWREADY;
    logic [DATA_W-1:0] S_AXI_WDATA;
    logic              S_AXI_WLAST;
    logic              S_AXI_WVALID;
    logic              S_AXI_WREADY;
    logic [ID_W-1:0]   S_AXI_BID;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY;
    logic [ID_W-1:0]   S_AXI_ARID;
    logic [7:0]        S_AXI_ARLEN;
    logic              S_AXI_ARVALID;
    logic              S_AXI_ARREADY;
    logic [ID_W-1:0]   S_AXI_RID;
    logic [DATA_W-1:0] S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RLAST;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARVALID,
        input  S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY,
        output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY,
        output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_BREADY,
        output S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARVALID,
        output S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY,
        input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
    );

endinterface

// File: rtl/axi_stream_dut_bridge_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push is accepted while full
// provided a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage is not reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/axi_stream_dut_bridge.sv
// AXI4 burst slave feeding a backpressure-free streaming DUT through credit-managed FIFOs.
// Optional statistics counters enabled by defining AXI_BRIDGE_STATS_EN.
module axi_stream_dut_bridge
    import axi_bridge_pkg::*;
#(
    parameter int unsigned ID_W      = 4,
    parameter int unsigned DATA_W    = 512,
    parameter int unsigned IN_DEPTH  = 32,
    parameter int unsigned OUT_DEPTH = 32
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESET,
    axi_stream_dut_bridge_if.slave s_axi,
    output logic                  dut_in_valid,
    output logic [DATA_W-1:0]     dut_in_data,
    input  logic                  dut_out_valid,
    input  logic [DATA_W-1:0]     dut_out_data
`ifdef AXI_BRIDGE_STATS_EN
    ,
    output logic [31:0]           stat_wr_beats,
    output logic [31:0]           stat_rd_beats,
    output logic [31:0]           stat_drop
`endif
);

    localparam int unsigned CRED_W = $clog2(OUT_DEPTH + 1);

    wr_state_t         wr_state_q;
    rd_state_t         rd_state_q;
    logic              awready_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;
    logic [ID_W-1:0]   bid_q;
    logic [LEN_W-1:0]  awlen_q;
    logic [LEN_W-1:0]  wr_cnt_q;
    logic              wr_err_q;
    logic              arready_q;
    logic [ID_W-1:0]   rid_q;
    logic [LEN_W-1:0]  arlen_q;
    logic [LEN_W-1:0]  rd_cnt_q;
    logic              drop_err_q;
    logic [CRED_W-1:0] credit_q;
    logic [CRED_W-1:0] credit_d;
    logic              dut_in_valid_q;
    logic [DATA_W-1:0] dut_in_data_q;

    logic              in_full, in_empty, in_pop;
    logic [DATA_W-1:0] in_head;
    logic              out_full, out_empty;
    logic [DATA_W-1:0] out_head;
    logic              wready, w_hs, rvalid, r_hs, drop;

    assign in_pop = !in_empty && (credit_q != '0);
    assign wready = (wr_state_q == WR_DATA) && (!in_full || in_pop);
    assign w_hs   = s_axi.S_AXI_WVALID && wready;
    assign rvalid = (rd_state_q == RD_DATA) && !out_empty;
    assign r_hs   = rvalid && s_axi.S_AXI_RREADY;
    assign drop   = dut_out_valid && out_full && !r_hs;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk     (S_AXI_ACLK),
        .rst     (S_AXI_ARESET),
        .push_i  (w_hs),
        .data_i  (s_axi.S_AXI_WDATA),
        .pop_i   (in_pop),
        .head_o  (in_head),
        .full_o  (in_full),
        .empty_o (in_empty)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk     (S_AXI_ACLK),
        .rst     (S_AXI_ARESET),
        .push_i  (dut_out_valid),
        .data_i  (dut_out_data),
        .pop_i   (r_hs),
        .head_o  (out_head),
        .full_o  (out_full),
        .empty_o (out_empty)
    );

    // Credits track free output-FIFO slots, counting beats in flight through the DUT.
    always_comb begin
        credit_d = credit_q;
        case ({in_pop, r_hs})
            2'b10:   credit_d = credit_q - CRED_W'(1);
            2'b01:   credit_d = credit_q + CRED_W'(1);
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            credit_q       <= CRED_W'(OUT_DEPTH);
            dut_in_valid_q <= 1'b0;
            dut_in_data_q  <= '0;
            drop_err_q     <= 1'b0;
        end else begin
            credit_q       <= credit_d;
            dut_in_valid_q <= in_pop;
            if (in_pop) dut_in_data_q <= in_head;
            if (drop)   drop_err_q    <= 1'b1;
        end
    end

    // Write FSM; a WLAST mismatch on any beat poisons the burst response.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wr_state_q <= WR_IDLE;
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            bid_q      <= '0;
            awlen_q    <= '0;
            wr_cnt_q   <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            case (wr_state_q)
                WR_IDLE: begin
                    awready_q <= 1'b1;
                    if (s_axi.S_AXI_AWVALID && awready_q) begin
                        awready_q  <= 1'b0;
                        bid_q      <= s_axi.S_AXI_AWID;
                        awlen_q    <= s_axi.S_AXI_AWLEN;
                        wr_cnt_q   <= '0;
                        wr_err_q   <= 1'b0;
                        wr_state_q <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        wr_cnt_q <= wr_cnt_q + LEN_W'(1);
                        if (wr_cnt_q == awlen_q) begin
                            bvalid_q   <= 1'b1;
                            bresp_q    <= (wr_err_q || !s_axi.S_AXI_WLAST) ? RESP_SLVERR : RESP_OKAY;
                            wr_state_q <= WR_RESP;
                        end else if (s_axi.S_AXI_WLAST) begin
                            wr_err_q <= 1'b1;
                        end
                    end
                end
                WR_RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wr_state_q <= WR_IDLE;
                    end
                end
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end

    // Read FSM; beats come straight from the output FIFO head.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rid_q      <= '0;
            arlen_q    <= '0;
            rd_cnt_q   <= '0;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    arready_q <= 1'b1;
                    if (s_axi.S_AXI_ARVALID && arready_q) begin
                        arready_q  <= 1'b0;
                        rid_q      <= s_axi.S_AXI_ARID;
                        arlen_q    <= s_axi.S_AXI_ARLEN;
                        rd_cnt_q   <= '0;
                        rd_state_q <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_hs) begin
                        rd_cnt_q <= rd_cnt_q + LEN_W'(1);
                        if (rd_cnt_q == arlen_q) begin
                            arready_q  <= 1'b1;
                            rd_state_q <= RD_IDLE;
                        end
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_BID     = bid_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RID     = rid_q;
    assign s_axi.S_AXI_RVALID  = rvalid;
    assign s_axi.S_AXI_RDATA   = rvalid ? out_head : '0;
    assign s_axi.S_AXI_RLAST   = rvalid && (rd_cnt_q == arlen_q);
    assign s_axi.S_AXI_RRESP   = (rvalid && drop_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign dut_in_valid        = dut_in_valid_q;
    assign dut_in_data         = dut_in_data_q;

    a_no_drop: assert property (@(posedge S_AXI_ACLK) disable iff (S_AXI_ARESET) !drop);

`ifdef AXI_BRIDGE_STATS_EN
    logic [31:0] stat_wr_q, stat_rd_q, stat_drop_q;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            stat_wr_q   <= '0;
            stat_rd_q   <= '0;
            stat_drop_q <= '0;
        end else begin
            if (w_hs) stat_wr_q   <= sat_inc(stat_wr_q);
            if (r_hs) stat_rd_q   <= sat_inc(stat_rd_q);
            if (drop) stat_drop_q <= sat_inc(stat_drop_q);
        end
    end

    assign stat_wr_beats = stat_wr_q;
    assign stat_rd_beats = stat_rd_q;
    assign stat_drop     = stat_drop_q;
`endif

endmodule

// File: tb/tb_axi_stream_dut_bridge.sv
// Self-checking bench for axi_stream_dut_bridge with a 1-cycle loopback DUT model.
module tb_axi_stream_dut_bridge;
    import axi_bridge_pkg::*;

    localparam int unsigned ID_W  = 4;
    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_stream_dut_bridge_if #(.ID_W(ID_W), .DATA_W(DW)) axi ();

    logic          dut_in_valid;
    logic [DW-1:0] dut_in_data;
    logic          dut_out_valid;
    logic [DW-1:0] dut_out_data;
`ifdef AXI_BRIDGE_STATS_EN
    logic [31:0] stat_wr_beats, stat_rd_beats, stat_drop;
`endif

    axi_stream_dut_bridge #(
        .ID_W(ID_W), .DATA_W(DW), .IN_DEPTH(DEPTH), .OUT_DEPTH(DEPTH)
    ) u_dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .s_axi         (axi.slave),
        .dut_in_valid  (dut_in_valid),
        .dut_in_data   (dut_in_data),
        .dut_out_valid (dut_out_valid),
        .dut_out_data  (dut_out_data)
`ifdef AXI_BRIDGE_STATS_EN
        ,
        .stat_wr_beats (stat_wr_beats),
        .stat_rd_beats (stat_rd_beats),
        .stat_drop     (stat_drop)
`endif
    );

    // Loopback DUT: echoes its input one cycle later.
    always @(posedge clk) begin
        if (rst) begin
            dut_out_valid <= 1'b0;
            dut_out_data  <= '0;
        end else begin
            dut_out_valid <= dut_in_valid;
            dut_out_data  <= dut_in_data;
        end
    end

    int feed_cnt = 0;
    int w_hs_cnt = 0;
    always @(posedge clk) begin
        if (dut_in_valid) feed_cnt++;
        if (axi.S_AXI_WVALID && axi.S_AXI_WREADY) w_hs_cnt++;
    end

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] sb_q[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic expired(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic axi_write(input logic [ID_W-1:0] id, input int len, input logic [DW-1:0] base,
                             input int wl_beat, input logic [1:0] exp_resp);
        int n;
        axi.S_AXI_AWID    = id;
        axi.S_AXI_AWLEN   = 8'(len);
        axi.S_AXI_AWVALID = 1'b1;
        n = 0;
        while (!axi.S_AXI_AWREADY) begin
            tick(1); n++;
            if (n > 200) begin expired("aw_handshake"); axi.S_AXI_AWVALID = 1'b0; return; end
        end
        tick(1);
        axi.S_AXI_AWVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            axi.S_AXI_WDATA  = base + DW'(i);
            axi.S_AXI_WLAST  = (i == wl_beat);
            axi.S_AXI_WVALID = 1'b1;
            n = 0;
            while (!axi.S_AXI_WREADY) begin
                tick(1); n++;
                if (n > 200) begin expired("w_handshake"); axi.S_AXI_WVALID = 1'b0; return; end
            end
            sb_q.push_back(axi.S_AXI_WDATA);
            tick(1);
        end
        axi.S_AXI_WVALID = 1'b0;
        axi.S_AXI_WLAST  = 1'b0;
        axi.S_AXI_BREADY = 1'b1;
        n = 0;
        while (!axi.S_AXI_BVALID) begin
            tick(1); n++;
            if (n > 200) begin expired("b_handshake"); axi.S_AXI_BREADY = 1'b0; return; end
        end
        chk("bid", DW'(axi.S_AXI_BID), DW'(id));
        chk("bresp", DW'(axi.S_AXI_BRESP), DW'(exp_resp));
        tick(1);
        axi.S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [ID_W-1:0] id, input int len, input bit rnd);
        int n;
        logic [DW-1:0] exp;
        axi.S_AXI_ARID    = id;
        axi.S_AXI_ARLEN   = 8'(len);
        axi.S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!axi.S_AXI_ARREADY) begin
            tick(1); n++;
            if (n > 200) begin expired("ar_handshake"); axi.S_AXI_ARVALID = 1'b0; return; end
        end
        tick(1);
        axi.S_AXI_ARVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            n = 0;
            forever begin
                axi.S_AXI_RREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (axi.S_AXI_RVALID && axi.S_AXI_RREADY) break;
                tick(1); n++;
                if (n > 400) begin expired("r_beat"); axi.S_AXI_RREADY = 1'b0; return; end
            end
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rdata: got %0h want no beat", axi.S_AXI_RDATA);
            end else begin
                exp = sb_q.pop_front();
                chk("rdata", axi.S_AXI_RDATA, exp);
            end
            chk("rlast", DW'(axi.S_AXI_RLAST), DW'(i == len));
            chk("rid", DW'(axi.S_AXI_RID), DW'(id));
            chk("rresp", DW'(axi.S_AXI_RRESP), DW'(RESP_OKAY));
            tick(1);
        end
        axi.S_AXI_RREADY = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_awready"}, DW'(axi.S_AXI_AWREADY), '0);
        chk({tag, "_wready"},  DW'(axi.S_AXI_WREADY),  '0);
        chk({tag, "_bvalid"},  DW'(axi.S_AXI_BVALID),  '0);
        chk({tag, "_bresp"},   DW'(axi.S_AXI_BRESP),   '0);
        chk({tag, "_bid"},     DW'(axi.S_AXI_BID),     '0);
        chk({tag, "_arready"}, DW'(axi.S_AXI_ARREADY), '0);
        chk({tag, "_rvalid"},  DW'(axi.S_AXI_RVALID),  '0);
        chk({tag, "_rlast"},   DW'(axi.S_AXI_RLAST),   '0);
        chk({tag, "_rresp"},   DW'(axi.S_AXI_RRESP),   '0);
        chk({tag, "_rid"},     DW'(axi.S_AXI_RID),     '0);
        chk({tag, "_rdata"},   axi.S_AXI_RDATA,        '0);
        chk({tag, "_dinv"},    DW'(dut_in_valid),      '0);
    endtask

    typedef struct {
        logic [ID_W-1:0] id;
        int              len;
        logic [DW-1:0]   base;
        int              wl_beat;
        logic [1:0]      bresp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f0, w0, n;
        bit seen;

        vecs[0] = '{4'h3, 3, 64'h1,   3,  RESP_OKAY};
        vecs[1] = '{4'h5, 0, 64'h100, 0,  RESP_OKAY};
        vecs[2] = '{4'h9, 2, 64'h200, 1,  RESP_SLVERR};
        vecs[3] = '{4'hF, 1, 64'h300, -1, RESP_SLVERR};
        vecs[4] = '{4'h6, 3, 64'h400, 0,  RESP_SLVERR};

        axi.S_AXI_AWID = '0; axi.S_AXI_AWLEN = '0; axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WDATA = '0; axi.S_AXI_WLAST = 1'b0; axi.S_AXI_WVALID = 1'b0;
        axi.S_AXI_BREADY = 1'b0;
        axi.S_AXI_ARID = '0; axi.S_AXI_ARLEN = '0; axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_RREADY = 1'b0;

        rst = 1'b1;
        tick(2);
        chk_all_zero("reset");
        rst = 1'b0;
        tick(1);
        chk("awready_idle", DW'(axi.S_AXI_AWREADY), 1);
        chk("arready_idle", DW'(axi.S_AXI_ARREADY), 1);

        // Loopback bursts, including WLAST protocol errors.
        for (int v = 0; v < 5; v++) begin
            f0 = feed_cnt;
            axi_write(vecs[v].id, vecs[v].len, vecs[v].base, vecs[v].wl_beat, vecs[v].bresp);
            tick(6);
            chk("feed_beats", DW'(feed_cnt - f0), DW'(vecs[v].len + 1));
            axi_read(vecs[v].id ^ 4'hA, vecs[v].len, 1'b0);
        end

        // Backpressure: output FIFO full and no credits, so only the input FIFO fills.
        axi_write(4'h1, 3, 64'h1000, 3, RESP_OKAY);
        tick(8);
        w0 = w_hs_cnt;
        fork
            axi_write(4'h2, 7, 64'h2000, 7, RESP_OKAY);
            begin
                tick(30);
                chk("bp_wbeats", DW'(w_hs_cnt - w0), DW'(DEPTH));
                chk("bp_wready", DW'(axi.S_AXI_WREADY), 0);
                axi_read(4'h3, 7, 1'b0);
                axi_read(4'h4, 3, 1'b0);
            end
        join

        // Read issued before any data exists must stall.
        fork
            axi_read(4'h7, 1, 1'b0);
            begin
                tick(3);
                seen = 1'b0;
                repeat (10) begin
                    if (axi.S_AXI_RVALID) seen = 1'b1;
                    tick(1);
                end
                chk("stall_rvalid", DW'(seen), 0);
                axi_write(4'h8, 1, 64'h3000, 1, RESP_OKAY);
            end
        join

        // Reset in the middle of a write burst.
        axi.S_AXI_AWID = 4'h1; axi.S_AXI_AWLEN = 8'd3; axi.S_AXI_AWVALID = 1'b1;
        n = 0;
        while (!axi.S_AXI_AWREADY && n < 200) begin tick(1); n++; end
        tick(1);
        axi.S_AXI_AWVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            axi.S_AXI_WDATA = 64'h4000 + DW'(i);
            axi.S_AXI_WVALID = 1'b1;
            n = 0;
            while (!axi.S_AXI_WREADY && n < 200) begin tick(1); n++; end
            tick(1);
        end
        axi.S_AXI_WVALID = 1'b0;
        rst = 1'b1;
        tick(1);
        chk_all_zero("midrst");
        rst = 1'b0;
        sb_q.delete();
        f0 = feed_cnt;
        tick(6);
        chk("midrst_nofeed", DW'(feed_cnt - f0), 0);
        fork
            axi_read(4'hB, 0, 1'b0);
            begin
                tick(3);
                seen = 1'b0;
                repeat (8) begin
                    if (axi.S_AXI_RVALID) seen = 1'b1;
                    tick(1);
                end
                chk("midrst_outempty", DW'(seen), 0);
                axi_write(4'hE, 0, 64'h5000, 0, RESP_OKAY);
            end
        join

        // Overlapping 16-beat write and read with random RREADY.
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        sb_q.delete();
        tick(2);
        fork
            axi_write(4'hC, 15, 64'h6000, 15, RESP_OKAY);
            axi_read(4'hD, 15, 1'b1);
        join
        tick(2);
        chk("sb_empty", DW'(sb_q.size()), 0);
`ifdef AXI_BRIDGE_STATS_EN
        chk("stat_wr", DW'(stat_wr_beats), 16);
        chk("stat_rd", DW'(stat_rd_beats), 16);
        chk("stat_drop", DW'(stat_drop), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
